// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: line-state enum, frame size and frame/parity helpers.
// Shared by the device transmitter and the host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame image, bit 0 goes on the wire first: start, data LSB first, parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] d);
        return {1'b1, ps2_odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO holding scan-code bytes waiting for the transmitter.
// Push and pop may both occur in one cycle; a push while full is dropped.
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: serialises scan-code bytes into 11-bit frames,
// generating ps2_clk itself, with a forced idle gap between frames.
// Optional build macro PS2_TX_FIFO_EN adds a 4-entry input FIFO; without it the
// frame register is the only byte holding register and ready = ~busy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | lines released high, waiting for a byte
// ST_HIGH | ps2_clk high phase of current bit; ps2_data set on entry
// ST_LOW  | ps2_clk low phase of current bit; ps2_data held
// ST_GAP  | lines high for GAP cycles before the next frame may start
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int GAP         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam logic [15:0] PH_LOAD  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state_q, state_d;
    logic [3:0]                bit_q, bit_d;
    logic [15:0]               phase_q, phase_d;
    logic [15:0]               gap_q, gap_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      init_q;

    logic       accept;
    logic       slot_open;
    logic       take;
    logic       ready_raw;
    logic       pending;
    logic [7:0] pend_byte;

    assign busy      = (state_q != ST_IDLE);
    assign ready     = init_q && ready_raw;
    assign accept    = valid && ready;
    assign slot_open = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0));
    assign take      = slot_open && pending;

`ifdef PS2_TX_FIFO_EN
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    // An empty FIFO is bypassed when a frame can start at once, so the first
    // HIGH cycle still follows acceptance directly.
    assign pending   = !fifo_empty || accept;
    assign pend_byte = fifo_empty ? data_in : fifo_dout;
    assign fifo_pop  = take && !fifo_empty;
    assign fifo_push = accept && !(take && fifo_empty);
    assign ready_raw = !fifo_full;

    ps2_tx_fifo #(
        .DEPTH (4),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (data_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
`else
    assign pending   = accept;
    assign pend_byte = data_in;
    assign ready_raw = !busy;
`endif

    // Line outputs decode straight from registered state; data only moves with bit_q.
    assign ps2_clk  = (state_q != ST_LOW);
    assign ps2_data = ((state_q == ST_HIGH) || (state_q == ST_LOW)) ? frame_q[bit_q] : 1'b1;

    // State and counter registers; ready stays low until the first clock after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            phase_q <= '0;
            gap_q   <= '0;
            frame_q <= '1;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            init_q  <= 1'b1;
        end
    end

    // Next-state logic: phase and gap timers count down to a terminal zero.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_HIGH;
                    bit_d   = '0;
                    phase_d = PH_LOAD;
                    frame_d = ps2_build_frame(pend_byte);
                end
            end
            ST_HIGH: begin
                if (phase_q == '0) begin
                    state_d = ST_LOW;
                    phase_d = PH_LOAD;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            ST_LOW: begin
                if (phase_q == '0) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q + 4'd1;
                        phase_d = PH_LOAD;
                    end
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    if (take) begin
                        state_d = ST_HIGH;
                        bit_d   = '0;
                        phase_d = PH_LOAD;
                        frame_d = ps2_build_frame(pend_byte);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a bit-level scoreboard: expected frame
// bits are queued when a byte is driven and popped at each ps2_clk falling edge.
module tb_ps2_device_tx;

    localparam int HP    = 8;
    localparam int GP    = 16;
    localparam int FRAME = 22 * HP;
`ifdef PS2_TX_FIFO_EN
    localparam bit POKE = 1'b0;
`else
    localparam bit POKE = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          exp_q[$];
    int          falls_total = 0;
    logic [10:0] obs_bits = '0;

    always #5 clk = ~clk;

    ps2_device_tx #(
        .HALF_PERIOD (HP),
        .GAP         (GP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid    (valid),
        .ready    (ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected wire bits, parity derived by counting ones.
    task automatic push_frame(input logic [7:0] b);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_q.push_back((ones % 2) == 0);
        exp_q.push_back(1'b1);
    endtask

    // Samples lines on the falling clk edge: phase lengths, data stability, frame bits.
    task automatic monitor();
        logic prev_c = 1'b1;
        logic prev_d = 1'b1;
        int   run = 0;
        int   fidx = 0;
        bit   e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_c = 1'b1;
                prev_d = 1'b1;
                run    = 0;
                fidx   = 0;
            end else begin
                if (ps2_clk !== prev_c) begin
                    if (prev_c == 1'b0) begin
                        chk("low_phase_len", run, HP);
                    end else begin
                        if (fidx > 0) chk("high_phase_len", run, HP);
                        chk("fall_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("frame_bit", ps2_data, e);
                        end
                        obs_bits[fidx] = ps2_data;
                        falls_total++;
                        fidx = (fidx == 10) ? 0 : fidx + 1;
                    end
                    run = 1;
                end else begin
                    if (ps2_clk == 1'b0) chk("data_stable_low", ps2_data, prev_d);
                    run++;
                end
                prev_c = ps2_clk;
                prev_d = ps2_data;
            end
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", ready, 1);
    endtask

    // Sends one byte and checks frame timing through to idle.
    task automatic send_and_check(input logic [7:0] b, input bit poke);
        int f0 = falls_total;
        wait_ready();
        push_frame(b);
        data_in = b;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        valid   = 1'b0;
        data_in = 8'h00;
        chk("first_high_clk", ps2_clk, 1);
        chk("start_bit_data", ps2_data, 0);
        chk("busy_in_frame", busy, 1);
        for (int n = 1; n <= FRAME + GP; n++) begin
            @(posedge clk);
            #1;
            if (poke && n == 50) begin
                chk("ready_low_busy", ready, 0);
                valid   = 1'b1;
                data_in = 8'h55;
            end else begin
                valid   = 1'b0;
                data_in = 8'h00;
            end
            if (n == FRAME - 1) chk("last_low_clk", ps2_clk, 0);
            if (n == FRAME) begin
                chk("gap_clk", ps2_clk, 1);
                chk("gap_data", ps2_data, 1);
                chk("gap_busy", busy, 1);
            end
            if (n == FRAME + GP - 1) chk("gap_end_busy", busy, 1);
            if (n == FRAME + GP) begin
                chk("idle_busy", busy, 0);
                chk("idle_ready", ready, 1);
            end
        end
        chk("fall_count", falls_total - f0, 11);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #1;
        chk("rst_ready", ready, 0);
        chk("rst_clk", ps2_clk, 1);
        chk("rst_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", ready, 1);

        send_and_check(8'h1C, POKE);
        chk("frame_1c_bits", obs_bits, 11'b10000111000);
        send_and_check(8'h00, 1'b0);
        chk("parity_00", obs_bits[9], 1);
        send_and_check(8'hFF, 1'b0);
        chk("parity_ff", obs_bits[9], 1);
        send_and_check(8'h01, 1'b0);
        chk("parity_01", obs_bits[9], 0);
        send_and_check(8'hA5, 1'b0);

        // Reset in the low phase of bit 5.
        wait_ready();
        push_frame(8'h1C);
        data_in = 8'h1C;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (11 * HP + 2) @(posedge clk);
        #2;
        chk("pre_rst_clk_low", ps2_clk, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_clk", ps2_clk, 1);
        chk("mid_rst_data", ps2_data, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst2", ready, 1);
        chk("no_edge_after_rst", ps2_clk, 1);
        send_and_check(8'h1C, 1'b0);
        chk("frame_1c_after_rst", obs_bits, 11'b10000111000);

`ifdef PS2_TX_FIFO_EN
        begin
            int f0 = falls_total;
            wait_ready();
            push_frame(8'hF0);
            data_in = 8'hF0;
            valid   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            push_frame(8'h1C);
            data_in = 8'h1C;
            @(posedge clk);
            #1;
            valid = 1'b0;
            chk("fifo_ready", ready, 1);
            for (int k = 2; k <= 2 * FRAME + GP + GP; k++) begin
                @(posedge clk);
                #1;
                if (k == FRAME + GP + HP - 1) chk("fifo_gap_high", ps2_clk, 1);
                if (k == FRAME + GP + HP) chk("fifo_gap_fall", ps2_clk, 0);
            end
            chk("fifo_idle", busy, 0);
            chk("fifo_falls", falls_total - f0, 22);
            chk("fifo_sb_drained", exp_q.size(), 0);
            chk("fifo_second_1c", obs_bits, 11'b10000111000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
